// File: rtl/wm8731_i2c_target_pkg.sv
// wm8731_i2c_target_pkg: shared codec constants, target FSM states and small helpers.
// Rev 1.0
`default_nettype none
package wm8731_i2c_target_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      ADDR    = 4'd1,
      ACK_A   = 4'd2,
      BYTE_HI = 4'd3,
      ACK_H   = 4'd4,
      BYTE_LO = 4'd5,
      ACK_L   = 4'd6,
      IGNORE  = 4'd7
   } state_t;

   // 7-bit bus addresses selected by the CSB strap.
   localparam logic [6:0] WM_ADDR_CSB0 = 7'h1A;
   localparam logic [6:0] WM_ADDR_CSB1 = 7'h1B;

   localparam logic [6:0] WM_R_LLINE_IN  = 7'h00;
   localparam logic [6:0] WM_R_RLINE_IN  = 7'h01;
   localparam logic [6:0] WM_R_ANALOG    = 7'h04;
   localparam logic [6:0] WM_R_DIGITAL   = 7'h05;
   localparam logic [6:0] WM_R_POWER     = 7'h06;
   localparam logic [6:0] WM_R_IFACE     = 7'h07;
   localparam logic [6:0] WM_R_SAMPLING  = 7'h08;
   localparam logic [6:0] WM_R_ACTIVE    = 7'h09;
   localparam logic [6:0] WM_R_RESET     = 7'h0F;

   localparam logic [3:0] LAST_BIT = 4'd7;

   function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] dev);
      return addr_byte == {dev, 1'b0};
   endfunction

   function automatic state_t ack_next(input state_t s);
      case (s)
         ACK_A:   return BYTE_HI;
         ACK_H:   return BYTE_LO;
         default: return IGNORE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop synchronizer plus FILT_LEN-sample stability filter for one I2C line.
// Rev 1.0
`default_nettype none
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [1:0]          sync;
   logic [FILT_LEN-1:0] hist;

   // Everything resets to 1 so an idle bus is assumed and no false START appears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '1;
         hist <= '1;
         dout <= 1'b1;
      end else begin
         sync <= {sync[0], din};
         hist <= FILT_LEN'({hist, sync[1]});
         if (&hist)
            dout <= 1'b1;
         else if (~|hist)
            dout <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wm8731_i2c_target.sv
// wm8731_i2c_target: write-only I2C target that decodes 3-byte WM8731 register writes.
// Rev 1.0
`default_nettype none
module wm8731_i2c_target
   import wm8731_i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = WM_ADDR_CSB0,
   parameter int         FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] reg_addr,
   output logic [8:0] reg_data,
   output logic       busy,
   output logic       addr_nack
);

   logic       scl_f, sda_f, scl_q, sda_q;
   logic       scl_rise, scl_fall, start_det, stop_det;
   state_t     state, nxt_state;
   logic [3:0] cnt, nxt_cnt;
   logic [7:0] shreg, nxt_shreg, byte_hi, nxt_byte_hi, rx_byte;
   logic       nxt_sda_oe, nxt_wr_valid, nxt_addr_nack, nxt_busy;
   logic [6:0] nxt_reg_addr;
   logic [8:0] nxt_reg_data;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(clk), .rst_n(rst_n), .din(scl_i), .dout(scl_f)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(clk), .rst_n(rst_n), .din(sda_i), .dout(sda_f)
   );

   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;
   // Requiring SCL high in both cycles keeps SDA edges that coincide with SCL edges from being read as bus conditions.
   assign start_det = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
   assign rx_byte   = {shreg[6:0], sda_f};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q     <= 1'b1;
         sda_q     <= 1'b1;
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         byte_hi   <= '0;
         sda_oe    <= 1'b0;
         wr_valid  <= 1'b0;
         addr_nack <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= '0;
         reg_data  <= '0;
      end else begin
         scl_q     <= scl_f;
         sda_q     <= sda_f;
         state     <= nxt_state;
         cnt       <= nxt_cnt;
         shreg     <= nxt_shreg;
         byte_hi   <= nxt_byte_hi;
         sda_oe    <= nxt_sda_oe;
         wr_valid  <= nxt_wr_valid;
         addr_nack <= nxt_addr_nack;
         busy      <= nxt_busy;
         reg_addr  <= nxt_reg_addr;
         reg_data  <= nxt_reg_data;
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_cnt       = cnt;
      nxt_shreg     = shreg;
      nxt_byte_hi   = byte_hi;
      nxt_sda_oe    = sda_oe;
      nxt_wr_valid  = 1'b0;
      nxt_addr_nack = 1'b0;
      nxt_reg_addr  = reg_addr;
      nxt_reg_data  = reg_data;

      if (start_det) begin
         nxt_state  = ADDR;
         nxt_cnt    = '0;
         nxt_sda_oe = 1'b0;
      end else if (stop_det) begin
         nxt_state  = IDLE;
         nxt_cnt    = '0;
         nxt_sda_oe = 1'b0;
      end else begin
         case (state)
            ADDR, BYTE_HI, BYTE_LO: begin
               if (scl_rise) begin
                  nxt_shreg = rx_byte;
                  nxt_cnt   = cnt + 4'd1;
                  if (cnt == LAST_BIT) begin
                     nxt_cnt = '0;
                     if (state == ADDR) begin
                        if (is_write_to(rx_byte, DEV_ADDR)) begin
                           nxt_state = ACK_A;
                        end else begin
                           nxt_addr_nack = 1'b1;
                           nxt_state     = IGNORE;
                        end
                     end else if (state == BYTE_HI) begin
                        nxt_state = ACK_H;
                     end else begin
                        nxt_reg_addr = byte_hi[7:1];
                        nxt_reg_data = {byte_hi[0], rx_byte};
                        nxt_wr_valid = 1'b1;
                        nxt_state    = ACK_L;
                     end
                  end
               end
            end
            ACK_A, ACK_H, ACK_L: begin
               // First falling edge drives the ACK, the second one (after the 9th clock) releases it.
               if (scl_fall) begin
                  if (!sda_oe) begin
                     nxt_sda_oe = 1'b1;
                     if (state == ACK_H)
                        nxt_byte_hi = shreg;
                  end else begin
                     nxt_sda_oe = 1'b0;
                     nxt_state  = ack_next(state);
                  end
               end
            end
            default: ;
         endcase
      end

      nxt_busy = (nxt_state != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_wm8731_i2c_target.sv
// tb_wm8731_i2c_target: two targets (default and 7'h55) on one bus, driven by an I2C master model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_wm8731_i2c_target;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       oe0, oe1, wv0, wv1, busy0, busy1, nk0, nk1;
   logic [6:0] ra0, ra1;
   logic [8:0] rd0, rd1;

   always #10 clk = ~clk;

   assign sda_bus = sda_m & ~oe0 & ~oe1;

   wm8731_i2c_target u_dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_oe(oe0), .wr_valid(wv0), .reg_addr(ra0), .reg_data(rd0),
      .busy(busy0), .addr_nack(nk0)
   );

   wm8731_i2c_target #(.DEV_ADDR(7'h55)) u_dut55 (
      .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_oe(oe1), .wr_valid(wv1), .reg_addr(ra1), .reg_data(rd1),
      .busy(busy1), .addr_nack(nk1)
   );

   // Cycle counts of each pulse output; a correct pulse contributes exactly one cycle.
   int wv_cnt [2];
   int nk_cnt [2];
   int oe0_cyc;

   always @(posedge clk) begin
      if (wv0) wv_cnt[0] <= wv_cnt[0] + 1;
      if (wv1) wv_cnt[1] <= wv_cnt[1] + 1;
      if (nk0) nk_cnt[0] <= nk_cnt[0] + 1;
      if (nk1) nk_cnt[1] <= nk_cnt[1] + 1;
      if (oe0) oe0_cyc   <= oe0_cyc + 1;
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   int         q       = 12;
   int         exp_wv [2];
   int         exp_nk [2];
   logic [6:0] exp_ra [2];
   logic [8:0] exp_rd [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] dev_of(input int d);
      return (d == 0) ? 7'h1A : 7'h55;
   endfunction

   task automatic wq(input int n = 1);
      repeat (n * q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq(4);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rst_in_ack, output bit ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; wq();
         scl_m = 1'b1; wq(2);
         scl_m = 1'b0; wq();
      end
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      ack = ~sda_bus;
      if (rst_in_ack) begin
         check("oe_before_rst", oe0, 1);
         rst_n = 1'b0;
         #1;
         check("oe_async_release", oe0, 0);
         @(negedge clk);
         check("busy_in_rst", {busy0, busy1}, 0);
         rst_n = 1'b1;
      end
      wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic check_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s:wv%0d", tag, d), wv_cnt[d], exp_wv[d]);
         check($sformatf("%s:nack%0d", tag, d), nk_cnt[d], exp_nk[d]);
         check($sformatf("%s:addr%0d", tag, d), (d == 0) ? ra0 : ra1, exp_ra[d]);
         check($sformatf("%s:data%0d", tag, d), (d == 0) ? rd0 : rd1, exp_rd[d]);
      end
      check({tag, ":idle"}, {busy0, busy1}, 0);
   endtask

   // Start, n bytes, stop; the expected outcome follows from the address rules alone.
   task automatic txn(input logic [7:0] b0, b1, b2, b3, input int n, input string tag);
      logic [7:0] bs [4];
      bit         ack;
      bit         hit [2];
      bs = '{b0, b1, b2, b3};
      i2c_start();
      check({tag, ":busy"}, {busy0, busy1}, 2'b11);
      for (int d = 0; d < 2; d++) hit[d] = (b0 == {dev_of(d), 1'b0});
      for (int k = 0; k < n; k++) begin
         send_byte(bs[k], 1'b0, ack);
         check($sformatf("%s:ack%0d", tag, k), ack, (k < 3) && (hit[0] || hit[1]));
      end
      i2c_stop();
      for (int d = 0; d < 2; d++) begin
         if (!hit[d]) begin
            exp_nk[d]++;
         end else if (n >= 3) begin
            exp_wv[d]++;
            exp_ra[d] = bs[1][7:1];
            exp_rd[d] = {bs[1][0], bs[2]};
         end
      end
      check_state(tag);
   endtask

   initial begin
      bit         ack;
      int         oe_before;
      logic [7:0] a;
      logic [7:0] picks [5];
      picks = '{8'h34, 8'hAA, 8'h35, 8'hAB, 8'h00};
      for (int d = 0; d < 2; d++) begin
         exp_ra[d] = '0;
         exp_rd[d] = '0;
      end

      repeat (5) @(negedge clk);
      check("rst_outs", {oe0, oe1, wv0, wv1, nk0, nk1, busy0, busy1, ra0, ra1, rd0, rd1}, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // 100 kHz write to the 7'h55 target; the default target must stay silent.
      q = 125;
      oe_before = oe0_cyc;
      txn(8'hAA, 8'h3C, 8'hC3, 8'h00, 3, "dev55");
      check("dev55:reg_addr", ra1, 7'h1E);
      check("dev55:reg_data", rd1, 9'h0C3);
      check("dev55:dflt_oe", oe0_cyc - oe_before, 0);
      q = 12;

      txn(8'h34, 8'h1E, 8'h00, 8'h00, 3, "r15");
      check("r15:reg_addr", ra0, 7'h0F);
      check("r15:reg_data", rd0, 9'h000);

      txn(8'h34, 8'h0E, 8'h00, 8'h00, 2, "stop2");
      txn(8'h35, 8'h12, 8'h34, 8'h00, 3, "read");
      txn(8'h34, 8'h0C, 8'h5A, 8'h77, 4, "extra");

      // Restart after the address byte, then a full write.
      i2c_start();
      send_byte(8'h34, 1'b0, ack);
      check("rstart:ack_first", ack, 1);
      exp_nk[1]++;
      txn(8'h34, 8'h12, 8'h81, 8'h00, 3, "rstart");
      check("rstart:reg_addr", ra0, 7'h09);
      check("rstart:reg_data", rd0, 9'h081);

      // Reset pulse while the second byte is being acknowledged.
      i2c_start();
      send_byte(8'h34, 1'b0, ack);
      check("rstmid:ack0", ack, 1);
      send_byte(8'h1E, 1'b1, ack);
      exp_nk[1]++;
      for (int d = 0; d < 2; d++) begin
         exp_ra[d] = '0;
         exp_rd[d] = '0;
      end
      i2c_stop();
      check_state("rstmid");
      txn(8'h34, 8'h02, 8'h55, 8'h00, 3, "post_rst");

      for (int t = 0; t < 12; t++) begin
         a = picks[$urandom_range(4, 0)];
         if (a == 8'h00) a = 8'($urandom);
         txn(a, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(4, 1)),
             $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wm8731_i2c_target.md
WM8731_I2C_TARGET -- requirements
Module: wm8731_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit device address (WM8731 with CSB=0).
REQ-002 SHALL have parameter FILT_LEN, default 3, the number of consecutive equal samples required before a synchronized SCL/SDA level is accepted.
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz system clock; all logic in this domain.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port scl_i, input, 1 bit: I2C clock from the bus (asynchronous).
REQ-006 SHALL have port sda_i, input, 1 bit: I2C data from the bus (asynchronous).
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 = pull SDA low (ACK); 0 = release the line.
REQ-008 SHALL have port wr_valid, output, 1 bit: one-cycle pulse when a complete 3-byte write has been accepted.
REQ-009 SHALL have port reg_addr, output, 7 bits: WM8731 register address from the last accepted write.
REQ-010 SHALL have port reg_data, output, 9 bits: WM8731 register data from the last accepted write.
REQ-011 SHALL have port busy, output, 1 bit: high from a detected START until STOP or abort.
REQ-012 SHALL have port addr_nack, output, 1 bit: one-cycle pulse when an address byte is not acknowledged.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-flop synchronizers, then through the FILT_LEN stability filter.
REQ-014 SHALL detect START (filtered SDA falls while SCL is high) and STOP (filtered SDA rises while SCL is high) in the cycle after the filtered change.
REQ-015 SHALL sample SDA, MSB first, on each filtered SCL rising edge, and SHALL change sda_oe only on filtered SCL falling edges.
REQ-016 SHALL implement states IDLE, ADDR, ACK_A, BYTE_HI, ACK_H, BYTE_LO, ACK_L, IGNORE, with a 4-bit bit counter and an 8-bit shift register.
REQ-017 SHALL go from IDLE to ADDR on START.
REQ-018 SHALL, after 8 address bits, go to ACK_A if the byte equals {DEV_ADDR, 1'b0}; otherwise it SHALL pulse addr_nack, keep sda_oe=0, and go to IGNORE.
REQ-019 SHALL, in each ACK_x state, assert sda_oe from the falling edge after bit 8 until the falling edge after the 9th clock.
REQ-020 SHALL go from ACK_A to BYTE_HI.
REQ-021 SHALL go from ACK_H to BYTE_LO.
REQ-022 SHALL go from ACK_L to IGNORE.
REQ-023 SHALL, on the 8th SCL rising edge of BYTE_LO, load reg_addr=byte_hi[7:1] and reg_data={byte_hi[0], byte_lo}, and pulse wr_valid in the following cycle.
REQ-024 SHALL hold reg_addr and reg_data until the next accepted write.
REQ-025 SHALL NACK (sda_oe=0) every byte received in IGNORE, which is left only by START or STOP.
REQ-026 SHALL treat a repeated START in any state as a restart: go to ADDR, clear the bit counter, release sda_oe, and produce no wr_valid.
REQ-027 SHALL treat a STOP in any state before BYTE_LO completes as an abort: go to IDLE, produce no wr_valid, and leave reg_addr/reg_data unchanged.
REQ-028 SHALL NACK read requests (R/W=1) exactly like an address mismatch.
REQ-029 SHALL give START/STOP priority over bit sampling when both are detected in the same cycle.
REQ-030 SHALL bound latency from the filtered 8th SCL rise of BYTE_LO to wr_valid at 1 clk.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE, sda_oe=0, wr_valid=0, addr_nack=0, busy=0, reg_addr=0, reg_data=0, and all synchronizer/filter flops to 1 (idle bus).
REQ-032 SHALL, on reset assertion mid-transfer, release SDA immediately (asynchronously), and SHALL afterwards wait for a fresh START.

Structure
REQ-033 SHALL take from the shared codec package: the state enum, WM8731 address constants (7'h1A/7'h1B), and register-number constants (e.g. R15 reset = 7'h0F).
REQ-034 SHALL implement synchronizer plus filter as one sub-module, i2c_line_filter, instantiated for SCL and SDA.

Verification
REQ-035 SHALL pass this scenario: DEV_ADDR=7'h55, I2C functional model sends 0xAA,0x3C,0xC3 at 100 kHz -> three ACKs, wr_valid one pulse, reg_addr=7'h1E, reg_data=9'h0C3.
REQ-036 SHALL pass this scenario: default DEV_ADDR, write 0x34,0x1E,0x00 -> reg_addr=7'h0F, reg_data=9'h000, one wr_valid pulse.
REQ-037 SHALL pass this scenario: default DEV_ADDR, address byte 0xAA -> addr_nack pulse, sda_oe never asserted, no wr_valid, outputs unchanged.
REQ-038 SHALL pass this scenario: STOP after the second byte -> no wr_valid, busy=0, previous reg_addr/reg_data retained.
REQ-039 SHALL pass this scenario: repeated START after the first byte, then a full write 0x34,0x12,0x81 -> one wr_valid pulse, reg_addr=7'h09, reg_data=9'h081.
REQ-040 SHALL pass this scenario: rst_n pulsed low during the ACK of byte 2 -> sda_oe=0 immediately, state IDLE, next full write accepted.
